// File: rtl/writeback_queue_if.sv
// writeback_queue_if
//   Bundles the writeback stage traffic: the ALU and long-latency result
//   handshakes, the registered register-file write port, the pending-write
//   mask and the sticky ordering-error flag.
//   master : result producers / register file side (drives valid + payload)
//   slave  : the writeback_queue itself (drives ready, write port, mask, flag)
interface writeback_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic                       alu_valid;
    logic                       alu_ready;
    logic [ADDR_WIDTH-1:0]      alu_rd;
    logic [DATA_WIDTH-1:0]      alu_data;

    logic                       mem_valid;
    logic                       mem_ready;
    logic [ADDR_WIDTH-1:0]      mem_rd;
    logic [DATA_WIDTH-1:0]      mem_data;

    logic                       ctrl_reg_w;
    logic [ADDR_WIDTH-1:0]      reg_num_w;
    logic [DATA_WIDTH-1:0]      w_data;

    logic [2**ADDR_WIDTH-1:0]   pending_mask;
    logic                       order_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  ctrl_reg_w, reg_num_w, w_data,
        input  pending_mask, order_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output ctrl_reg_w, reg_num_w, w_data,
        output pending_mask, order_err
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue
//   Writeback stage feeding the integer register file write port. Single-cycle
//   ALU results win arbitration; long-latency results wait in an in-order FIFO
//   and are popped whenever the ALU is not writing. A starvation counter forces
//   one ALU hold cycle after STARVE_LIMIT consecutive lost cycles of a waiting
//   FIFO head. The write port is registered (one write per cycle).
// Ports
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : writeback_queue_if.slave
//         alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//         mem_valid/mem_ready/mem_rd/mem_data   long-latency result handshake
//         ctrl_reg_w/reg_num_w/w_data           registered register-file write
//         pending_mask                          destinations held in the FIFO
//         order_err                             sticky ALU-over-pending hazard
module writeback_queue #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    writeback_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned NREG  = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] q_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [STV_W-1:0]      starve_cnt;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_rd_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  order_err_q;

    logic                  full;
    logic                  empty;
    logic                  hold;
    logic                  alu_fire;
    logic                  alu_wr;
    logic                  push;
    logic                  pop;
    logic [NREG-1:0]       pend;
    logic [PTR_W-1:0]      off;

    // Arbitration. A hold cycle is simply the cycle in which the starve
    // counter sits at its limit; the counter only grows while the FIFO is
    // non-empty, so the head is always there to pop.
    always_comb begin
        full     = (count == CNT_W'(FIFO_DEPTH));
        empty    = (count == '0);
        hold     = (starve_cnt == STV_W'(STARVE_LIMIT));
        alu_fire = bus.alu_valid && !hold;
        alu_wr   = alu_fire && (bus.alu_rd != '0);
        pop      = !empty && !alu_wr;
        push     = bus.mem_valid && !full;
    end

    // Pending mask: slot i is live when its distance from the read pointer
    // (modulo depth) is below the occupancy count.
    always_comb begin
        pend = '0;
        off  = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if ({1'b0, off} < count) begin
                pend[q_rd[i]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= '0;
            wr_en_q     <= 1'b0;
            wr_rd_q     <= '0;
            wr_data_q   <= '0;
            order_err_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                q_rd[i]   <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (push) begin
                q_rd[wr_ptr]   <= bus.mem_rd;
                q_data[wr_ptr] <= bus.mem_data;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end

            if (pop) begin
                starve_cnt <= '0;
            end else if (!empty && alu_wr) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end

            // Heads targeting x0 are popped without a write.
            if (alu_wr) begin
                wr_en_q   <= 1'b1;
                wr_rd_q   <= bus.alu_rd;
                wr_data_q <= bus.alu_data;
            end else if (pop && (q_rd[rd_ptr] != '0)) begin
                wr_en_q   <= 1'b1;
                wr_rd_q   <= q_rd[rd_ptr];
                wr_data_q <= q_data[rd_ptr];
            end else begin
                wr_en_q   <= 1'b0;
            end

            if (alu_wr && pend[bus.alu_rd]) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign bus.alu_ready    = !hold;
    assign bus.mem_ready    = !full;
    assign bus.ctrl_reg_w   = wr_en_q;
    assign bus.reg_num_w    = wr_rd_q;
    assign bus.w_data       = wr_data_q;
    assign bus.pending_mask = pend;
    assign bus.order_err    = order_err_q;
endmodule
